// File: rtl/elm_hidden_neuron_mac.sv
// MAC datapath for one ELM hidden neuron: streams activations against weight memory,
// accumulates with saturation, adds bias and emits one clamped Q(fracBits) result per vector.
module elm_hidden_neuron_mac #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10,
  parameter int numWeight    = 784,
  parameter int fracBits     = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [dataWidth-1:0]      myinput,
  input  logic                      myinputValid,
  input  logic [2*dataWidth-1:0]    bias,
  output logic                      ren,
  output logic [addressWidth:0]     raddr,
  input  logic [dataWidth-1:0]      wout,
  output logic [dataWidth-1:0]      out,
  output logic                      outvalid
);

  localparam int AW = addressWidth + 1;
  localparam int SW = 2 * dataWidth;
  localparam logic signed [SW-1:0] OUT_MAX = SW'((2 ** (dataWidth - 1)) - 1);
  localparam logic signed [SW-1:0] OUT_MIN = -OUT_MAX - SW'(1);

  logic                 is_last;
  logic [dataWidth-1:0] in_d;
  logic                 in_valid_d;
  logic                 in_last_d;
  logic [SW-1:0]        prod;
  logic                 prod_valid;
  logic                 prod_last;
  logic [SW-1:0]        sum;
  logic                 bias_pending;
  logic [SW-1:0]        acc_next;
  logic [SW-1:0]        biased;
  logic signed [SW-1:0] shifted;
  logic [dataWidth-1:0] clamped;

  // Two's complement add that clamps instead of wrapping on overflow.
  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] s;
    s = a + b;
    if ((a[SW-1] == b[SW-1]) && (s[SW-1] != a[SW-1]))
      s = a[SW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    return s;
  endfunction

  assign ren     = myinputValid & rstn;
  assign is_last = (raddr == AW'(numWeight - 1));

  always_comb begin
    acc_next = sat_add(sum, prod);
    biased   = sat_add(sum, bias);
    shifted  = $signed(biased) >>> fracBits;
    clamped  = shifted[dataWidth-1:0];
    if (shifted > OUT_MAX)
      clamped = OUT_MAX[dataWidth-1:0];
    else if (shifted < OUT_MIN)
      clamped = OUT_MIN[dataWidth-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      raddr      <= '0;
      in_d       <= '0;
      in_valid_d <= 1'b0;
      in_last_d  <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      if (myinputValid)
        raddr <= is_last ? '0 : raddr + AW'(1);
      in_d       <= myinput;
      in_valid_d <= myinputValid;
      in_last_d  <= myinputValid & is_last;
      prod       <= SW'($signed(in_d)) * SW'($signed(wout));
      prod_valid <= in_valid_d;
      prod_last  <= in_valid_d & in_last_d;
    end
  end

  // During the bias-add cycle the accumulator restarts from the next vector's
  // first product (if present) so back-to-back vectors lose nothing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum          <= '0;
      bias_pending <= 1'b0;
      out          <= '0;
      outvalid     <= 1'b0;
    end else begin
      bias_pending <= prod_valid & prod_last;
      if (bias_pending) begin
        out      <= clamped;
        outvalid <= 1'b1;
        sum      <= prod_valid ? prod : '0;
      end else begin
        outvalid <= 1'b0;
        if (prod_valid)
          sum <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_elm_hidden_neuron_mac.sv
// Self-checking bench for elm_hidden_neuron_mac with a 4-weight vector and a
// scoreboard of expected results and arrival cycles.
`timescale 1ns/1ps
module tb_elm_hidden_neuron_mac;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] myinput;
  logic        myinputValid;
  logic [31:0] bias;
  logic        ren;
  logic [10:0] raddr;
  logic [15:0] wout = '0;
  logic [15:0] out;
  logic        outvalid;

  logic [15:0] cur_w;
  int          cycle = 0;
  int          errors = 0;
  int          checks = 0;
  int          exp_addr = 0;
  int          exp_val_q[$];
  int          exp_cyc_q[$];

  elm_hidden_neuron_mac #(
    .dataWidth(16),
    .addressWidth(10),
    .numWeight(NW),
    .fracBits(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .myinput(myinput),
    .myinputValid(myinputValid),
    .bias(bias),
    .ren(ren),
    .raddr(raddr),
    .wout(wout),
    .out(out),
    .outvalid(outvalid)
  );

  always #5 clk = ~clk;

  // Weight memory model: one-cycle read latency.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (ren) wout <= cur_w;
  end

  always @(negedge clk) begin
    if (rstn === 1'b1 && outvalid === 1'b1) begin
      checks++;
      if (exp_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_outvalid: out=%0d at cycle %0d, none required", $signed(out), cycle);
      end else begin
        int ev;
        int ec;
        ev = exp_val_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (int'($signed(out)) !== ev) begin
          errors++;
          $display("FAIL out_value: got %0d required %0d", $signed(out), ev);
        end
        checks++;
        if (cycle !== ec) begin
          errors++;
          $display("FAIL out_latency: got cycle %0d required cycle %0d", cycle, ec);
        end
      end
    end
  end

  task automatic send_vec(input int x, input int w, input logic [31:0] b,
                          input int gap_max, input int n, input int expv);
    bias = b;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0 && i > 0) begin
        repeat ($urandom_range(gap_max, 1)) begin
          @(negedge clk);
          myinputValid = 1'b0;
        end
      end
      @(negedge clk);
      myinputValid = 1'b1;
      myinput      = 16'(x);
      cur_w        = 16'(w);
      #1;
      checks++;
      if (ren !== 1'b1) begin
        errors++;
        $display("FAIL ren_on_input: got %b required 1", ren);
      end
      checks++;
      if (raddr !== 11'(exp_addr)) begin
        errors++;
        $display("FAIL raddr_seq: got %0d required %0d", raddr, exp_addr);
      end
      exp_addr = (exp_addr + 1) % NW;
      if (i == NW - 1) begin
        exp_val_q.push_back(expv);
        exp_cyc_q.push_back(cycle + 4);
      end
    end
  endtask

  task automatic drain();
    repeat (10) begin
      @(negedge clk);
      myinputValid = 1'b0;
    end
    checks++;
    if (exp_val_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_val_q.size());
      exp_val_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    myinputValid = 1'b1;
    myinput = 16'd256;
    cur_w = 16'd128;
    bias = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b required 0", ren); end
    checks++;
    if (raddr !== 11'd0) begin errors++; $display("FAIL reset_raddr: got %0d required 0", raddr); end
    checks++;
    if (out !== 16'd0) begin errors++; $display("FAIL reset_out: got %0d required 0", out); end
    checks++;
    if (outvalid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b required 0", outvalid); end
    myinputValid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_addr = 0;
  endtask

  task automatic test_basic();
    send_vec(256, 128, 32'd0, 0, NW, 512);
    drain();
    checks++;
    if (int'($signed(out)) !== 512) begin
      errors++;
      $display("FAIL out_hold: got %0d required 512", $signed(out));
    end
  endtask

  task automatic test_bias_bubbles();
    send_vec(256, 128, 32'd65536, 3, NW, 768);
    drain();
  endtask

  task automatic test_saturation();
    send_vec(32767, 32767, 32'h7fff_ffff, 0, NW, 32767);
    drain();
    send_vec(-32767, 32767, 32'h8000_0000, 0, NW, -32768);
    drain();
  endtask

  task automatic test_back_to_back();
    send_vec(256, 128, 32'd0, 0, NW, 512);
    send_vec(256, -128, 32'd0, 0, NW, -512);
    drain();
  endtask

  task automatic test_reset_mid();
    send_vec(300, 200, 32'd0, 0, 2, 0);
    @(negedge clk);
    myinputValid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (raddr !== 11'd0) begin errors++; $display("FAIL midreset_raddr: got %0d required 0", raddr); end
    checks++;
    if (out !== 16'd0) begin errors++; $display("FAIL midreset_out: got %0d required 0", out); end
    checks++;
    if (outvalid !== 1'b0) begin errors++; $display("FAIL midreset_outvalid: got %b required 0", outvalid); end
    @(negedge clk);
    rstn = 1'b1;
    exp_addr = 0;
    send_vec(256, 128, 32'd0, 0, NW, 512);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_bubbles();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elm_hidden_neuron_mac.md
# elm_hidden_neuron_mac

Multiply-accumulate datapath for one ELM hidden-layer neuron. It sits directly downstream of that neuron's weight memory. It consumes a stream of input activations, issues one read address per activation, and multiplies each activation by the weight returned one cycle later. After the last of `numWeight` inputs it adds the bias and emits one saturated fixed-point pre-activation result per input vector for the activation stage.

## Interface
- `dataWidth`, 16: width of activations, weights and output; signed two's complement.
- `addressWidth`, 10: weight memory address width; the read address port is `addressWidth+1` bits.
- `numWeight`, 784: inputs (and weights) per vector.
- `fracBits`, 8: fractional bits of activations, weights and output.

- `clk`  in  1: clock; all state on rising edge.
- `rstn`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `myinput`  in  dataWidth: activation, signed Q(fracBits).
- `myinputValid`  in  1: `myinput` valid this cycle.
- `bias`  in  2*dataWidth: signed, 2*fracBits fractional bits; quasi-static, sampled at bias-add.
- `ren`  out  1: weight memory read enable.
- `raddr`  out  addressWidth+1: weight memory read address.
- `wout`  in  dataWidth: weight returned by memory; valid the cycle after `ren`.
- `out`  out  dataWidth: neuron pre-activation, signed Q(fracBits).
- `outvalid`  out  1: one-cycle pulse, `out` valid.

## Operation
- `ren` = `myinputValid & rstn` (combinational). `raddr` = address counter register.
- The address counter increments on each accepted input. It wraps from `numWeight-1` to 0, and the accepted input at `numWeight-1` is tagged "last".
- Bubbles (`myinputValid`=0) are allowed anywhere. The counter and pipeline advance only on valid data, and no timeout applies.
- Pipeline:
  - S1 registers `myinput`, its valid and its last flag, so they align with `wout`.
  - S2 registers the signed product `myinput_d * wout` (2*dataWidth bits, 2*fracBits fraction), plus its valid and last flag.
  - S3 is the accumulator `sum` (2*dataWidth bits).
- Accumulation: on S2 valid, `sum` ← sat(`sum` + product). Saturation applies when both operands have the same sign and the result sign differs: clamp to 2^(2*dataWidth-1)-1 or -2^(2*dataWidth-1).
- When the accumulated product was "last", a bias-pending flag is set. On the next edge:
  - `out` ← clamp(sat(`sum` + `bias`) >>> fracBits) to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
  - `outvalid` ← 1.
  - `sum` restarts. It loads the S2 product if S2 is valid that cycle (first product of the next vector), else 0. Back-to-back vectors lose no data.
- `outvalid` is 1 for exactly one cycle per vector. `out` holds its value until the next result.
- Reset (async assertion): counter, all pipeline valids/flags, `sum`, `out` and `outvalid` go to 0. A partial vector is discarded, and no `outvalid` is produced for it. After deassertion the next valid input is index 0.

## Timing
- Input accepted in cycle t → `raddr`/`ren` in cycle t → `wout` in t+1 → product registered at end of t+1 → accumulated at end of t+2.
- Last input of a vector in cycle t → `outvalid`=1 in cycle t+4. Fixed latency is 4 cycles, independent of bubbles before it.
- Full throughput is one input per cycle. Minimum spacing between `outvalid` pulses is `numWeight` cycles.
- Simultaneous bias-add and first product of the next vector is required to work, as described above.
- Reset values: `ren`=0, `raddr`=0, `out`=0, `outvalid`=0.

## Test plan
- Reset: hold `rstn`=0 with `myinputValid`=1 → `ren`=0, `raddr`=0, `out`=0, `outvalid`=0. Release → first valid input drives `raddr`=0 with `ren`=1.
- Basic vector: `numWeight`=4, `fracBits`=8. Inputs 256 ×4 contiguous, weights 128 each, `bias`=0 → `out`=512, `outvalid` pulse 4 cycles after the last input. `raddr` sequence 0,1,2,3.
- Bias and bubbles: same vector with 1–3 idle cycles between inputs and `bias`=65536 → `out`=768, still 4 cycles after the last input.
- Saturation: inputs 32767, weights 32767, `numWeight`=4, `bias`=2^31-1 → `sum` clamps and no wraparound occurs. `out`=32767. Negative mirror gives `out`=-32768.
- Back-to-back: two 4-input vectors with no gap. Vector A gives 512. Vector B uses weights -128, so 4 × 256 × -128 = -131072; with `bias`=0, `out`=-512. Two `outvalid` pulses 4 cycles apart, and `raddr` wraps 3→0.
- Reset mid-vector: assert `rstn`=0 after 2 of 4 inputs, release, then send a full vector → exactly one `outvalid` with the full-vector value. `raddr` restarts at 0.
